// File: rtl/chip8_trace_buffer_if.sv
// Signal bundle between the Chip8 core side and the trace buffer:
// sample/trigger inputs, read-out stream and status flags.
interface chip8_trace_buffer_if #(
    parameter int PC_W  = 12,
    parameter int OP_W  = 16,
    parameter int DEPTH = 64,
    parameter int RD_W  = PC_W + OP_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              arm;
    logic              sample_valid;
    logic [PC_W-1:0]   pc;
    logic [OP_W-1:0]   op;
    logic              trig_en;
    logic [PC_W-1:0]   trig_pc;
    logic              trig_force;
    logic              rd_req;
    logic [RD_W-1:0]   rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              armed;
    logic              triggered;
    logic              done;
    logic [CNT_W-1:0]  count;

    modport master (
        output arm, sample_valid, pc, op, trig_en, trig_pc, trig_force, rd_req,
        input  rd_data, rd_valid, rd_last, armed, triggered, done, count
    );

    modport slave (
        input  arm, sample_valid, pc, op, trig_en, trig_pc, trig_force, rd_req,
        output rd_data, rd_valid, rd_last, armed, triggered, done, count
    );
endinterface

// File: rtl/chip8_trace_buffer.sv
// Triggerable ring buffer of executed {pc, op} pairs, read back oldest-first.
// Define CHIP8_TRACE_TIMESTAMP_EN to prepend a 16-bit free-running cycle stamp to each entry.
module chip8_trace_buffer #(
    parameter int PC_W      = 12,
    parameter int OP_W      = 16,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32
) (
    input  logic                 SYS_CLK,
    input  logic                 CPU_RESETN,
    chip8_trace_buffer_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
`ifdef CHIP8_TRACE_TIMESTAMP_EN
    localparam int TS_W  = 16;
`else
    localparam int TS_W  = 0;
`endif
    localparam int EW    = TS_W + PC_W + OP_W;

    localparam logic [AW-1:0]    POST_INIT = AW'(POST_TRIG);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_POST  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    post_q, post_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic [EW-1:0]    rd_data_q, rd_data_d;

    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    wr_entry;
    logic             wr_en;
    logic             trig_hit;
    logic [AW-1:0]    rd_addr;
    logic [CNT_W-1:0] rem;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == FULL) ? c : c + 1'b1;
    endfunction

`ifdef CHIP8_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;

    assign ts_d     = ts_q + 16'd1;
    assign wr_entry = {ts_q, bus.pc, bus.op};

    always_ff @(posedge SYS_CLK) begin
        if (!CPU_RESETN) ts_q <= '0;
        else             ts_q <= ts_d;
    end
`else
    assign wr_entry = {bus.pc, bus.op};
`endif

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        post_d     = post_q;
        count_d    = count_q;
        left_d     = left_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;
        trig_hit   = bus.trig_force | (bus.sample_valid & bus.trig_en & (bus.pc == bus.trig_pc));
        // A full (wrapped) buffer starts at the oldest slot, which is the next write slot.
        rd_addr    = (state_q == S_DONE) ? ((count_q == FULL) ? wptr_q : '0) : rptr_q;
        rem        = (state_q == S_DONE) ? count_q : left_q;

        if (bus.arm) begin
            state_d = S_ARMED;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_ARMED, S_POST: begin
                    if (bus.sample_valid) begin
                        wr_en   = 1'b1;
                        wptr_d  = wptr_q + 1'b1;
                        count_d = sat_inc(count_q);
                    end
                    if (state_q == S_ARMED && trig_hit) begin
                        post_d  = POST_INIT;
                        state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
                    end else if (state_q == S_POST && bus.sample_valid) begin
                        post_d = post_q - 1'b1;
                        if (post_q == AW'(1)) state_d = S_DONE;
                    end
                end
                S_DONE, S_READ: begin
                    if (bus.rd_req) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = (count_q == '0) ? '0 : mem[rd_addr];
                        rptr_d     = rd_addr + 1'b1;
                        left_d     = rem - 1'b1;
                        if (rem <= CNT_W'(1)) begin
                            rd_last_d = 1'b1;
                            state_d   = S_IDLE;
                            count_d   = '0;
                        end else begin
                            state_d   = S_READ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state
    always_ff @(posedge SYS_CLK) begin
        if (!CPU_RESETN) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            post_q     <= '0;
            count_q    <= '0;
            left_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            post_q     <= post_d;
            count_q    <= count_d;
            left_q     <= left_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Data path: storage and read register carry no reset
    always_ff @(posedge SYS_CLK) begin
        rd_data_q <= rd_data_d;
        if (wr_en && CPU_RESETN) mem[wptr_q] <= wr_entry;
    end

    assign bus.rd_data   = rd_valid_q ? rd_data_q : '0;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.armed     = (state_q == S_ARMED) || (state_q == S_POST);
    assign bus.triggered = (state_q == S_POST) || (state_q == S_DONE) || (state_q == S_READ);
    assign bus.done      = (state_q == S_DONE) || (state_q == S_READ);
    assign bus.count     = count_q;
endmodule

// File: tb/tb_chip8_trace_buffer.sv
// Bench for chip8_trace_buffer: vector table, hand sequences for wrap/handshake/abort,
// and random traffic against a queue-based reference model.
module tb_chip8_trace_buffer;
    localparam int PC_W      = 12;
    localparam int OP_W      = 16;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 3;
    localparam int EW        = PC_W + OP_W;
`ifdef CHIP8_TRACE_TIMESTAMP_EN
    localparam int RD_W      = 16 + EW;
`else
    localparam int RD_W      = EW;
`endif

    localparam int M_IDLE = 0, M_ARM = 1, M_POST = 2, M_DONE = 3, M_READ = 4;

    logic SYS_CLK    = 1'b0;
    logic CPU_RESETN = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    chip8_trace_buffer_if #(.PC_W(PC_W), .OP_W(OP_W), .DEPTH(DEPTH), .RD_W(RD_W)) bus ();

    chip8_trace_buffer #(.PC_W(PC_W), .OP_W(OP_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
        .SYS_CLK    (SYS_CLK),
        .CPU_RESETN (CPU_RESETN),
        .bus        (bus)
    );

    typedef struct {
        logic        arm, sv, frc, rd;
        logic [11:0] pc;
        logic [15:0] op;
        logic        e_v, e_l, e_a, e_t, e_d;
        logic [3:0]  e_c;
        logic [27:0] e_data;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: capture history and read-out window as queues
    int           ph   = M_IDLE;
    int           left = 0;
    logic [EW-1:0] hist[$];
    logic [EW-1:0] win[$];
    logic          m_v, m_l;
    logic [EW-1:0] m_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit hit;
        m_v = 1'b0;
        m_l = 1'b0;
        m_d = '0;
        if (!CPU_RESETN) begin
            ph = M_IDLE; hist.delete(); win.delete();
        end else if (bus.arm) begin
            ph = M_ARM; hist.delete(); win.delete();
        end else if (ph == M_ARM || ph == M_POST) begin
            hit = bus.trig_force || (bus.sample_valid && bus.trig_en && bus.pc == bus.trig_pc);
            if (bus.sample_valid) begin
                hist.push_back({bus.pc, bus.op});
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            if (ph == M_ARM && hit) begin
                left = POST_TRIG;
                ph   = (left == 0) ? M_DONE : M_POST;
            end else if (ph == M_POST && bus.sample_valid) begin
                left--;
                if (left == 0) ph = M_DONE;
            end
            if (ph == M_DONE) win = hist;
        end else if ((ph == M_DONE || ph == M_READ) && bus.rd_req) begin
            m_v = 1'b1;
            if (win.size() == 0) begin
                m_l = 1'b1; ph = M_IDLE;
            end else begin
                m_d = win.pop_front();
                ph  = M_READ;
                if (win.size() == 0) begin m_l = 1'b1; ph = M_IDLE; end
            end
        end
    endtask

    function automatic logic [63:0] m_pack();
        logic [3:0] c;
        c = (ph == M_IDLE) ? 4'd0 : 4'(hist.size());
        return 64'({m_v, m_l, ph == M_ARM || ph == M_POST,
                    ph == M_POST || ph == M_DONE || ph == M_READ,
                    ph == M_DONE || ph == M_READ, c, m_d});
    endfunction

    function automatic logic [63:0] dut_pack();
        return 64'({bus.rd_valid, bus.rd_last, bus.armed, bus.triggered, bus.done,
                    bus.count, bus.rd_data[EW-1:0]});
    endfunction

    task automatic tick();
        model_step();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.arm = 1'b0; bus.sample_valid = 1'b0; bus.pc = '0; bus.op = '0;
        bus.trig_en = 1'b0; bus.trig_pc = '0; bus.trig_force = 1'b0; bus.rd_req = 1'b0;
    endtask

    function automatic vec_t mk(input logic arm, sv, frc, rd, input logic [11:0] pc,
                                input logic [15:0] op, input logic ev, el, ea, et, ed,
                                input logic [3:0] ec, input logic [27:0] edata);
        vec_t v;
        v.arm = arm; v.sv = sv; v.frc = frc; v.rd = rd; v.pc = pc; v.op = op;
        v.e_v = ev; v.e_l = el; v.e_a = ea; v.e_t = et; v.e_d = ed; v.e_c = ec; v.e_data = edata;
        return v;
    endfunction

    initial begin
        logic [11:0] p;
        logic [15:0] o;
        logic [15:0] stamps[4];
        int got;

        clear_inputs();
        // Table: arm, 4 samples, forced trigger, 3 post samples, 7 reads, idle read
        tbl.push_back(mk(1, 0, 0, 0, 12'h0, 16'h0, 0, 0, 1, 0, 0, 4'd0, 28'h0));
        for (int k = 0; k < 7; k++) begin
            p = 12'h200 + 12'(2 * k);
            o = 16'h6000 + 16'(k);
            if (k == 4)
                tbl.push_back(mk(0, 0, 1, 0, 12'h0, 16'h0, 0, 0, 1, 1, 0, 4'd4, 28'h0));
            tbl.push_back(mk(0, 1, 0, 0, p, o, 0, 0, k < 6, k >= 4, k == 6, 4'(k + 1), 28'h0));
        end
        for (int k = 0; k < 7; k++) begin
            p = 12'h200 + 12'(2 * k);
            o = 16'h6000 + 16'(k);
            tbl.push_back(mk(0, 0, 0, 1, 12'h0, 16'h0, 1, k == 6, 0, k < 6, k < 6,
                             (k < 6) ? 4'd7 : 4'd0, {p, o}));
        end
        tbl.push_back(mk(0, 0, 0, 1, 12'h0, 16'h0, 0, 0, 0, 0, 0, 4'd0, 28'h0));

        // Reset
        CPU_RESETN = 1'b0;
        tick(); tick();
        chk("rst_valid", 64'(bus.rd_valid), 64'd0);
        chk("rst_last", 64'(bus.rd_last), 64'd0);
        chk("rst_data", 64'(bus.rd_data), 64'd0);
        chk("rst_armed", 64'(bus.armed), 64'd0);
        chk("rst_triggered", 64'(bus.triggered), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        CPU_RESETN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.sample_valid = 1'b1; bus.pc = 12'h100; tick();
            bus.sample_valid = 1'b0; tick();
        end
        chk("idle_count", 64'(bus.count), 64'd0);
        chk("idle_armed", 64'(bus.armed), 64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.arm = tbl[i].arm; bus.sample_valid = tbl[i].sv; bus.trig_force = tbl[i].frc;
            bus.rd_req = tbl[i].rd; bus.pc = tbl[i].pc; bus.op = tbl[i].op;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(bus.rd_valid), 64'(tbl[i].e_v));
            chk($sformatf("vec%0d_last", i), 64'(bus.rd_last), 64'(tbl[i].e_l));
            chk($sformatf("vec%0d_data", i), 64'(bus.rd_data[EW-1:0]), 64'(tbl[i].e_data));
            chk($sformatf("vec%0d_armed", i), 64'(bus.armed), 64'(tbl[i].e_a));
            chk($sformatf("vec%0d_trig", i), 64'(bus.triggered), 64'(tbl[i].e_t));
            chk($sformatf("vec%0d_done", i), 64'(bus.done), 64'(tbl[i].e_d));
            chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(tbl[i].e_c));
        end
        clear_inputs();

        // Wrap with PC-match trigger, read with gapped requests
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        bus.trig_en = 1'b1; bus.trig_pc = 12'h20A;
        for (int j = 0; j < 20; j++) begin
            bus.sample_valid = 1'b1;
            bus.pc = 12'h200 + 12'(2 * j);
            bus.op = 16'h6000 + 16'(j);
            tick();
        end
        clear_inputs();
        chk("wrap_done", 64'(bus.done), 64'd1);
        chk("wrap_count", 64'(bus.count), 64'd8);
        got = 0;
        for (int c = 0; c < 24 && got < 8; c++) begin
            logic req;
            req = (c % 4 != 1);
            bus.rd_req = req;
            tick();
            chk($sformatf("hs%0d_valid", c), 64'(bus.rd_valid), 64'(req));
            if (req) begin
                p = 12'h202 + 12'(2 * got);
                o = 16'h6001 + 16'(got);
                chk($sformatf("wrap%0d_data", got), 64'(bus.rd_data[EW-1:0]), 64'({p, o}));
                chk($sformatf("wrap%0d_last", got), 64'(bus.rd_last), 64'(got == 7));
                got++;
            end
        end
        bus.rd_req = 1'b0;
        chk("wrap_entries", 64'(got), 64'd8);
        tick();
        chk("wrap_no_dup", 64'(bus.rd_valid), 64'd0);
        chk("wrap_idle_done", 64'(bus.done), 64'd0);

        // Abort during read-out
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.sample_valid = (k != 5);
            bus.trig_force   = (k == 5);
            bus.pc = 12'h300 + 12'(k);
            tick();
        end
        clear_inputs();
        chk("abort_done", 64'(bus.done), 64'd1);
        bus.rd_req = 1'b1;
        tick(); tick(); tick();
        bus.arm = 1'b1;
        tick();
        chk("abort_armed", 64'(bus.armed), 64'd1);
        chk("abort_count", 64'(bus.count), 64'd0);
        chk("abort_valid", 64'(bus.rd_valid), 64'd0);
        chk("abort_done_clr", 64'(bus.done), 64'd0);
        clear_inputs();

`ifdef CHIP8_TRACE_TIMESTAMP_EN
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.sample_valid = 1'b1; bus.trig_force = (k == 0); bus.pc = 12'h400 + 12'(k);
            tick();
            clear_inputs();
            if (k < 3) for (int g = 0; g < 4; g++) tick();
        end
        chk("ts_done", 64'(bus.done), 64'd1);
        bus.rd_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            stamps[k] = bus.rd_data[RD_W-1 -: 16];
        end
        bus.rd_req = 1'b0;
        for (int k = 1; k < 4; k++)
            chk($sformatf("ts_delta%0d", k), 64'(stamps[k] - stamps[k-1]), 64'd5);
`else
        stamps[0] = '0;
`endif

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            bus.arm          = ($urandom_range(0, 63) == 0);
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.pc           = 12'h200 + 12'(2 * $urandom_range(0, 7));
            bus.op           = 16'($urandom);
            bus.trig_en      = 1'($urandom_range(0, 1));
            bus.trig_pc      = 12'h200 + 12'(2 * $urandom_range(0, 7));
            bus.trig_force   = ($urandom_range(0, 31) == 0);
            bus.rd_req       = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("rand%0d", c), dut_pack(), m_pack());
        end
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
